// File: rtl/count_frame_tx.sv
// count_frame_tx: snapshots {mod,count} on a start request and shifts it out
// as a framed serial word: start 0, count LSB first, mod, even parity, stop 1.
// Each bit is held DIV clock cycles. Rejected starts while busy are counted.
module count_frame_tx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             mod,
  input  logic             start,
  output logic             sdata,
  output logic             busy,
  output logic             done,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned IDXW = $clog2(WIDTH + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH);
  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic            sdata_q, sdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      drop_q, drop_d;
  logic [7:0]      div_q, div_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [WIDTH:0]  snap_q, snap_d;
  logic            bit_end;

  assign bit_end = (div_q == '0);

  // Next-state, next-output, divider, bit index and drop counter.
  always_comb begin
    state_d = state_q;
    sdata_d = sdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    div_d   = div_q;
    idx_d   = idx_q;
    snap_d  = snap_q;

    // The divider counts down within a bit; the boundary cases below reload it.
    if (state_q != IDLE && !bit_end) begin
      div_d = div_q - 8'd1;
    end

    // Every request seen outside IDLE is rejected, including in the final STOP cycle.
    if (state_q != IDLE && start && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        sdata_d = 1'b1;
        busy_d  = 1'b0;
        if (start) begin
          snap_d  = {mod, count};
          state_d = START;
          sdata_d = 1'b0;
          busy_d  = 1'b1;
          div_d   = DIV_M1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          sdata_d = snap_q[0];
          div_d   = DIV_M1;
        end
      end
      DATA: begin
        if (bit_end) begin
          div_d = DIV_M1;
          if (idx_q == LAST_IDX) begin
            state_d = PARITY;
            sdata_d = ^snap_q;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            sdata_d = snap_q[idx_q + IDXW'(1)];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          sdata_d = 1'b1;
          div_d   = DIV_M1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          sdata_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sdata_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sdata_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      sdata_q <= sdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign sdata    = sdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_count_frame_tx.sv
// Directed bench for count_frame_tx: three instances (DIV=1, 3, 255) share
// the stimulus; each scenario checks the instance it targets.
module tb_count_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count = '0;
  logic       mod = 1'b0;
  logic       start = 1'b0;

  logic       sdata1, busy1, done1;
  logic [7:0] drop1;
  logic       sdata3, busy3, done3;
  logic [7:0] drop3;
  logic       sdata255, busy255, done255;
  logic [7:0] drop255;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  count_frame_tx #(.WIDTH(4), .DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .count(count), .mod(mod), .start(start),
    .sdata(sdata1), .busy(busy1), .done(done1), .drop_cnt(drop1)
  );

  count_frame_tx #(.WIDTH(4), .DIV(3)) u_d3 (
    .clk(clk), .rst(rst), .count(count), .mod(mod), .start(start),
    .sdata(sdata3), .busy(busy3), .done(done3), .drop_cnt(drop3)
  );

  count_frame_tx #(.WIDTH(4), .DIV(255)) u_d255 (
    .clk(clk), .rst(rst), .count(count), .mod(mod), .start(start),
    .sdata(sdata255), .busy(busy255), .done(done255), .drop_cnt(drop255)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Caller raises start at a negedge; bit i of exp is the line value in frame cycle i.
  task automatic frame_d1(input string tag, input logic [7:0] exp, input bit wiggle);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (wiggle) begin
        count = 4'($urandom);
        mod   = 1'($urandom);
      end
      check($sformatf("%s sdata[%0d]", tag, i), 32'(sdata1), 32'(exp[i]));
      check($sformatf("%s busy[%0d]", tag, i), 32'(busy1), 32'd1);
      check($sformatf("%s done[%0d]", tag, i), 32'(done1), 32'd0);
    end
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done1), 32'd1);
    check({tag, " busy end"}, 32'(busy1), 32'd0);
    check({tag, " idle line"}, 32'(sdata1), 32'd1);
    @(negedge clk);
    check({tag, " done cleared"}, 32'(done1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned accepts;
    int unsigned idle_cycles;
    int unsigned dones;
    logic        prev_busy;
    logic [7:0]  exp3;

    // Reset state and idle behaviour.
    do_reset();
    check("rst sdata", 32'(sdata1), 32'd1);
    check("rst busy", 32'(busy1), 32'd0);
    check("rst done", 32'(done1), 32'd0);
    check("rst drop", 32'(drop1), 32'd0);
    repeat (3) @(negedge clk);
    check("idle sdata", 32'(sdata1), 32'd1);
    check("idle done", 32'(done1), 32'd0);

    // count=1011, mod=1: parity 0.
    count = 4'b1011; mod = 1'b1; start = 1'b1;
    frame_d1("f1011", 8'b10110110, 1'b0);

    // count=0110, mod=0 with inputs scrambled every cycle after the accept edge.
    count = 4'b0110; mod = 1'b0; start = 1'b1;
    frame_d1("fwiggle", 8'b10001100, 1'b1);
    check("no drops yet", 32'(drop1), 32'd0);

    // DIV=3, count=0001, mod=0: parity 1, every bit held 3 cycles.
    do_reset();
    count = 4'b0001; mod = 1'b0; start = 1'b1;
    exp3 = 8'b11000010;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("div3 sdata[%0d]", c), 32'(sdata3), 32'(exp3[c / 3]));
      check($sformatf("div3 busy[%0d]", c), 32'(busy3), 32'd1);
    end
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) check("div3 busy end", 32'(busy3), 32'd0);
      if (done3) dones++;
    end
    check("div3 done count", dones, 32'd1);

    // start held for 20 edges: accepts on edges 1, 10 and 19 (one idle-high
    // cycle between frames), drops on edges 2-9, 11-18 and 20.
    do_reset();
    count = 4'b0101; mod = 1'b0; start = 1'b1;
    accepts = 0; idle_cycles = 0; prev_busy = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (busy1 && !prev_busy) accepts++;
      if (!busy1) begin
        idle_cycles++;
        check($sformatf("held idle line e%0d", e), 32'(sdata1), 32'd1);
      end
      prev_busy = busy1;
    end
    start = 1'b0;
    check("held accepts", accepts, 32'd3);
    check("held idle gaps", idle_cycles, 32'd2);
    check("held drop_cnt", 32'(drop1), 32'd17);

    // Reset mid-DATA after one drop, start held during reset, then a clean frame.
    do_reset();
    count = 4'b1011; mod = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    check("pre-rst drop", 32'(drop1), 32'd1);
    @(negedge clk);
    check("pre-rst busy", 32'(busy1), 32'd1);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    check("midrst sdata", 32'(sdata1), 32'd1);
    check("midrst busy", 32'(busy1), 32'd0);
    check("midrst done", 32'(done1), 32'd0);
    check("midrst drop", 32'(drop1), 32'd0);
    @(negedge clk);
    check("rst-held busy", 32'(busy1), 32'd0);
    check("rst-held drop", 32'(drop1), 32'd0);
    rst = 1'b1;
    frame_d1("postrst", 8'b10110110, 1'b0);

    // Saturation on the DIV=255 instance: one accept then 300 drops.
    do_reset();
    start = 1'b1;
    repeat (101) @(negedge clk);
    check("sat drop@100", 32'(drop255), 32'd100);
    repeat (200) @(negedge clk);
    start = 1'b0;
    check("sat busy", 32'(busy255), 32'd1);
    check("sat drop", 32'(drop255), 32'd255);
    @(negedge clk);
    check("sat hold", 32'(drop255), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
